// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, widths,
// default latencies and op classification helpers.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_pkg;

    localparam int unsigned MD_OP_W            = 3;
    localparam int unsigned MD_WORD_W          = 32;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    // Ops 4-7 only exist when the accumulate family is built in
    function automatic logic op_legal(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
        op_legal = (op <= MD_OP_W'(7));
`else
        op_legal = (op <= MD_OP_W'(MD_DIVU));
`endif
    endfunction

    function automatic logic op_is_div(input logic [MD_OP_W-1:0] op);
        op_is_div = (op == MD_OP_W'(MD_DIV)) || (op == MD_OP_W'(MD_DIVU));
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath: computes the next {hi,lo} from latched operands,
// latched op and the current HI/LO. Divide by zero returns {hi,lo} unchanged.
// Optional feature macro: MD_MADD_EN.
module md_core
    import md_pkg::*;
(
    input  logic [MD_WORD_W-1:0]   a,
    input  logic [MD_WORD_W-1:0]   b,
    input  logic [MD_OP_W-1:0]     op,
    input  logic [MD_WORD_W-1:0]   hi,
    input  logic [MD_WORD_W-1:0]   lo,
    output logic [2*MD_WORD_W-1:0] result_c
);

    logic [2*MD_WORD_W-1:0] prod_s;
    logic [2*MD_WORD_W-1:0] prod_u;
    logic [MD_WORD_W-1:0]   div_b;
    logic [MD_WORD_W-1:0]   a_mag;
    logic [MD_WORD_W-1:0]   b_mag;
    logic [MD_WORD_W-1:0]   q_mag;
    logic [MD_WORD_W-1:0]   r_mag;
    logic [MD_WORD_W-1:0]   q_s;
    logic [MD_WORD_W-1:0]   r_s;
    logic [MD_WORD_W-1:0]   q_u;
    logic [MD_WORD_W-1:0]   r_u;
    logic                   b_zero;

    // Products, sign-magnitude signed divide (avoids the MIN/-1 overflow case), unsigned divide
    always_comb begin
        prod_s = {{MD_WORD_W{a[MD_WORD_W-1]}}, a} * {{MD_WORD_W{b[MD_WORD_W-1]}}, b};
        prod_u = {MD_WORD_W'(0), a} * {MD_WORD_W'(0), b};
        b_zero = (b == MD_WORD_W'(0));
        div_b  = b_zero ? MD_WORD_W'(1) : b;
        a_mag  = a[MD_WORD_W-1]     ? (MD_WORD_W'(0) - a)     : a;
        b_mag  = div_b[MD_WORD_W-1] ? (MD_WORD_W'(0) - div_b) : div_b;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (a[MD_WORD_W-1] ^ div_b[MD_WORD_W-1]) ? (MD_WORD_W'(0) - q_mag) : q_mag;
        r_s    = a[MD_WORD_W-1] ? (MD_WORD_W'(0) - r_mag) : r_mag;
        q_u    = a / div_b;
        r_u    = a % div_b;
    end

    // Result select by op
    always_comb begin
        result_c = {hi, lo};
        case (md_op_e'(op))
            MD_MULT:  result_c = prod_s;
            MD_MULTU: result_c = prod_u;
            MD_DIV:   result_c = b_zero ? {hi, lo} : {r_s, q_s};
            MD_DIVU:  result_c = b_zero ? {hi, lo} : {r_u, q_u};
`ifdef MD_MADD_EN
            MD_MADD:  result_c = {hi, lo} + prod_s;
            MD_MADDU: result_c = {hi, lo} + prod_u;
            MD_MSUB:  result_c = {hi, lo} - prod_s;
            MD_MSUBU: result_c = {hi, lo} - prod_u;
`endif
            default:  result_c = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Holds busy for
// exactly MULT_CYCLES or DIV_CYCLES cycles, then commits the result.
// Optional feature macro: MD_MADD_EN (accumulate ops 4-7).
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic [MD_WORD_W-1:0]   a_q;
    logic [MD_WORD_W-1:0]   b_q;
    logic [MD_OP_W-1:0]     op_q;
    logic [2*MD_WORD_W-1:0] result_c;

    md_core u_core (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .hi       (hi),
        .lo       (lo),
        .result_c (result_c)
    );

    // Control FSM: launch/latch in IDLE, count down in RUN, commit on the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_legal(md_op)) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= md_op;
                        cnt   <= op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (hilo_we && !start) begin
                        if (hilo_sel) begin
                            hi <= A;
                        end else begin
                            lo <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= result_c[2*MD_WORD_W-1:MD_WORD_W];
                        lo    <= result_c[MD_WORD_W-1:0];
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default 5/10 cycle latencies).
// Honours MD_MADD_EN for the accumulate test.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_cmp;
    int n_err;
    int cyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (a),
        .B        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch an op; optionally disturb inputs mid-run; return observed busy cycles
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input bit disturb, output int cycles);
        md_op = op;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start  = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 50) begin
            cycles++;
            a     = $urandom;
            b     = $urandom;
            md_op = 3'($urandom_range(0, 7));
            if (disturb && cycles == 2) begin
                start    = 1'b1;
                md_op    = 3'd0;
                hilo_we  = 1'b1;
                hilo_sel = 1'b0;
                a        = 32'h0000AAAA;
            end
            step();
            start   = 1'b0;
            hilo_we = 1'b0;
        end
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] v);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        a        = v;
        step();
        hilo_we = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        a        = '0;
        b        = '0;
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        step();

        // MULT -2 * 3
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        // MULTU same operands
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        check("multu_cycles", 32'(cyc), 32'd5);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        // DIV -7 / 2
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
        check("div_cycles", 32'(cyc), 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // DIVU 7 / 2
        run_op(3'd3, 32'd7, 32'd2, 1'b0, cyc);
        check("divu_cycles", 32'(cyc), 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // DIV overflow case
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);

        // Preload via hilo_we, then DIVU by zero leaves them untouched
        write_hilo(1'b1, 32'h11);
        check("mthi", hi, 32'h11);
        write_hilo(1'b0, 32'h22);
        check("mtlo", lo, 32'h22);
        run_op(3'd3, 32'd100, 32'd0, 1'b0, cyc);
        check("div0_cycles", 32'(cyc), 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // start and hilo_we during RUN are ignored
        run_op(3'd0, 32'd5, 32'd7, 1'b1, cyc);
        check("cont_cycles", 32'(cyc), 32'd5);
        check("cont_hi", hi, 32'd0);
        check("cont_lo", lo, 32'd35);
        check("cont_idle", 32'(busy), 32'd0);

        // start and hilo_we together in IDLE: op launches, LO write dropped
        md_op    = 3'd3;
        a        = 32'd9;
        b        = 32'd4;
        start    = 1'b1;
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        step();
        start   = 1'b0;
        hilo_we = 1'b0;
        check("both_busy", 32'(busy), 32'd1);
        check("both_lo_kept", lo, 32'd35);
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            step();
        end
        check("both_lo", lo, 32'd2);
        check("both_hi", hi, 32'd1);

        // Accumulate op: legal only with MD_MADD_EN
        write_hilo(1'b1, 32'h0);
        write_hilo(1'b0, 32'hFFFFFFFF);
        run_op(3'd5, 32'd1, 32'd1, 1'b0, cyc);
`ifdef MD_MADD_EN
        check("maddu_cycles", 32'(cyc), 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_ignored_busy", 32'(cyc), 32'd0);
        check("maddu_ignored_hi", hi, 32'd0);
        check("maddu_ignored_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset during cycle 4 of a DIV aborts it
        md_op = 3'd3;
        a     = 32'd50;
        b     = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 15; i++) step();
        check("abort_hi_later", hi, 32'd0);
        check("abort_lo_later", lo, 32'd0);
        check("abort_busy_later", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
